vga_digit_display: RTL



---
 rtl/vga_digit_display.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_digit_display.sv
// VGA raster generator that renders a row of NUM_DIGITS scaled 5x7 BCD glyphs, snapshotting the digits once per frame.
// Build option: define VGA_DIGIT_HEX_GLYPHS_EN to render digit values 10..15 as A..F instead of blank cells.
module vga_digit_display #(
    parameter int          NUM_DIGITS = 11,
    parameter int          SCALE_LOG2 = 2,
    parameter int          X0         = 0,
    parameter int          Y0         = 0,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter logic [2:0]  FG_RGB     = 3'b111,
    parameter logic [2:0]  BG_RGB     = 3'b000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] num_data,
    output logic                    r,
    output logic                    g,
    output logic                    b,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CELL    = 32'sd8 <<< SCALE_LOG2;

    // Glyph rows packed top row first; each row is MSB = leftmost column.
    function automatic logic [34:0] glyph_rows(input logic [3:0] d);
        logic [34:0] rows;
        case (d)
            4'd0:    rows = 35'b01110_10001_10011_10101_11001_10001_01110;
            4'd1:    rows = 35'b00100_01100_00100_00100_00100_00100_01110;
            4'd2:    rows = 35'b01110_10001_00001_00010_00100_01000_11111;
            4'd3:    rows = 35'b11111_00010_00100_00010_00001_10001_01110;
            4'd4:    rows = 35'b00010_00110_01010_10010_11111_00010_00010;
            4'd5:    rows = 35'b11111_10000_11110_00001_00001_10001_01110;
            4'd6:    rows = 35'b00110_01000_10000_11110_10001_10001_01110;
            4'd7:    rows = 35'b11111_00001_00010_00100_01000_01000_01000;
            4'd8:    rows = 35'b01110_10001_10001_01110_10001_10001_01110;
            4'd9:    rows = 35'b01110_10001_10001_01111_00001_00010_01100;
`ifdef VGA_DIGIT_HEX_GLYPHS_EN
            4'd10:   rows = 35'b01110_10001_10001_11111_10001_10001_10001;
            4'd11:   rows = 35'b11110_10001_10001_11110_10001_10001_11110;
            4'd12:   rows = 35'b01110_10001_10000_10000_10000_10001_01110;
            4'd13:   rows = 35'b11100_10010_10001_10001_10001_10010_11100;
            4'd14:   rows = 35'b11111_10000_10000_11110_10000_10000_11111;
            4'd15:   rows = 35'b11111_10000_10000_11110_10000_10000_10000;
`endif
            default: rows = 35'b0;
        endcase
        return rows;
    endfunction

    logic [HW-1:0]           h_cnt_r;
    logic [VW-1:0]           v_cnt_r;
    logic [4*NUM_DIGITS-1:0] num_q_r;

    // Raster counters: h wraps at end of line and advances v, v wraps at end of frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (h_cnt_r == HW'(H_TOTAL - 32'sd1)) begin
            h_cnt_r <= '0;
            if (v_cnt_r == VW'(V_TOTAL - 32'sd1)) begin
                v_cnt_r <= '0;
            end else begin
                v_cnt_r <= v_cnt_r + VW'(1'b1);
            end
        end else begin
            h_cnt_r <= h_cnt_r + HW'(1'b1);
        end
    end

    // Digit snapshot on the last clock of the last active line, so a whole frame renders one value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_q_r <= '0;
        end else if ((h_cnt_r == HW'(H_TOTAL - 32'sd1)) && (v_cnt_r == VW'(V_ACTIVE - 32'sd1))) begin
            num_q_r <= num_data;
        end else begin
            num_q_r <= num_q_r;
        end
    end

    int            hc_s, vc_s, hx_s, vy_s;
    logic          active_s, in_row_s, hs_s, vs_s, fs_s;
    logic [IW-1:0] idx_s;

    // Stage-1 decode: position inside the digit row, active window and sync windows.
    always_comb begin
        hc_s     = int'(h_cnt_r);
        vc_s     = int'(v_cnt_r);
        hx_s     = hc_s - X0;
        vy_s     = vc_s - Y0;
        active_s = (hc_s < H_ACTIVE) && (vc_s < V_ACTIVE);
        in_row_s = (hx_s >= 32'sd0) && (hx_s < NUM_DIGITS * CELL) && (vy_s >= 32'sd0) && (vy_s < CELL);
        hs_s     = !((hc_s >= H_ACTIVE + H_FP) && (hc_s < H_ACTIVE + H_FP + H_SYNC));
        vs_s     = !((vc_s >= V_ACTIVE + V_FP) && (vc_s < V_ACTIVE + V_FP + V_SYNC));
        fs_s     = (hc_s == 32'sd0) && (vc_s == 32'sd0);
        // Leftmost cell holds the most significant digit; outside the row the index is parked at 0.
        if (in_row_s) begin
            idx_s = IW'(NUM_DIGITS - 32'sd1 - (hx_s >>> (32'sd3 + SCALE_LOG2)));
        end else begin
            idx_s = '0;
        end
    end

    logic [IW-1:0] idx1_r;
    logic [2:0]    gcol1_r, grow1_r;
    logic          act1_r, in_row1_r, hs1_r, vs1_r, fs1_r;

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx1_r    <= '0;
            gcol1_r   <= 3'd0;
            grow1_r   <= 3'd0;
            act1_r    <= 1'b0;
            in_row1_r <= 1'b0;
            hs1_r     <= 1'b1;
            vs1_r     <= 1'b1;
            fs1_r     <= 1'b0;
        end else begin
            idx1_r    <= idx_s;
            gcol1_r   <= hx_s[SCALE_LOG2 +: 3];
            grow1_r   <= vy_s[SCALE_LOG2 +: 3];
            act1_r    <= active_s;
            in_row1_r <= in_row_s;
            hs1_r     <= hs_s;
            vs1_r     <= vs_s;
            fs1_r     <= fs_s;
        end
    end

    logic [3:0]  digit_s;
    logic [34:0] glyph_s;
    logic [4:0]  row_bits_s;
    logic        pix_s;

    // Font lookup: cell columns 5..7 and row 7 are spacing.
    always_comb begin
        digit_s = 4'(num_q_r >> {idx1_r, 2'b00});
        glyph_s = glyph_rows(digit_s);
        case (grow1_r)
            3'd0:    row_bits_s = glyph_s[34:30];
            3'd1:    row_bits_s = glyph_s[29:25];
            3'd2:    row_bits_s = glyph_s[24:20];
            3'd3:    row_bits_s = glyph_s[19:15];
            3'd4:    row_bits_s = glyph_s[14:10];
            3'd5:    row_bits_s = glyph_s[9:5];
            3'd6:    row_bits_s = glyph_s[4:0];
            default: row_bits_s = 5'b00000;
        endcase
        if (gcol1_r < 3'd5) begin
            pix_s = row_bits_s[3'd4 - gcol1_r];
        end else begin
            pix_s = 1'b0;
        end
    end

    logic [2:0] rgb_r;
    logic       hs2_r, vs2_r, fs2_r;

    // Stage-2 output registers keep colour, syncs and frame strobe aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_r <= 3'b000;
            hs2_r <= 1'b1;
            vs2_r <= 1'b1;
            fs2_r <= 1'b0;
        end else begin
            if (!act1_r) begin
                rgb_r <= 3'b000;
            end else if (in_row1_r && pix_s) begin
                rgb_r <= FG_RGB;
            end else begin
                rgb_r <= BG_RGB;
            end
            hs2_r <= hs1_r;
            vs2_r <= vs1_r;
            fs2_r <= fs1_r;
        end
    end

    assign r           = rgb_r[2];
    assign g           = rgb_r[1];
    assign b           = rgb_r[0];
    assign h_sync      = hs2_r;
    assign v_sync      = vs2_r;
    assign frame_start = fs2_r;
endmodule
